// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for the ALU execute stage: upstream op channel, downstream
// result channel and the bring-up counters.
interface alu_exec_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic [2:0]            in_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_zero;
    logic                  out_carry;
    logic                  out_ovf;
    logic [2:0]            out_op;
    logic [CNT_WIDTH-1:0]  op_count;
    logic [CNT_WIDTH-1:0]  ovf_count;

    // The pipeline itself
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_ovf,
               out_op, op_count, ovf_count
    );

    // Whoever feeds ops in and drains results
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_ovf,
               out_op, op_count, ovf_count
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-stage execute wrapper around the combinational alu: stage 1 holds operands,
// stage 2 holds the result and flags, both with valid/ready backpressure.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUop,
    output logic             Overflow,
    output logic             CarryOut,
    output logic             Zero,
    output logic [WIDTH-1:0] Result
);
    logic [WIDTH-1:0] and_vec;
    logic [WIDTH-1:0] or_vec;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             slt_bit;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_vec[gi] = A[gi] & B[gi];
            assign or_vec[gi]  = A[gi] | B[gi];
        end
    endgenerate

    // Top bit of the zero-extended difference is the borrow, i.e. A < B unsigned
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};
    assign slt_bit  = $signed(A) < $signed(B);

    always_comb begin
        Result   = '0;
        CarryOut = 1'b0;
        Overflow = 1'b0;
        case (ALUop)
            3'b000: Result = and_vec;
            3'b001: Result = or_vec;
            3'b010: begin
                Result   = sum_ext[WIDTH-1:0];
                CarryOut = sum_ext[WIDTH];
                Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            3'b110: begin
                Result   = diff_ext[WIDTH-1:0];
                CarryOut = diff_ext[WIDTH];
                Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            3'b111: Result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: ;
        endcase
    end

    assign Zero = (Result == '0);
endmodule

module alu_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_exec_stage_if.slave     bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                  s1_valid_reg;
    logic [DATA_WIDTH-1:0] s1_a_reg;
    logic [DATA_WIDTH-1:0] s1_b_reg;
    logic [2:0]            s1_op_reg;

    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_result_reg;
    logic                  out_zero_reg;
    logic                  out_carry_reg;
    logic                  out_ovf_reg;
    logic [2:0]            out_op_reg;
    logic [CNT_WIDTH-1:0]  op_count_reg;
    logic [CNT_WIDTH-1:0]  ovf_count_reg;

    logic                  alu_ovf;
    logic                  alu_carry;
    logic                  alu_zero;
    logic [DATA_WIDTH-1:0] alu_result;

    logic s2_load;
    logic in_ready_int;
    logic in_fire;
    logic out_fire;

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .A        (s1_a_reg),
        .B        (s1_b_reg),
        .ALUop    (s1_op_reg),
        .Overflow (alu_ovf),
        .CarryOut (alu_carry),
        .Zero     (alu_zero),
        .Result   (alu_result)
    );

    // Ready is derived only from registered state and out_ready, never in_valid
    assign s2_load      = s1_valid_reg && (!out_valid_reg || bus.out_ready);
    assign in_ready_int = !s1_valid_reg || s2_load;
    assign in_fire      = bus.in_valid && in_ready_int;
    assign out_fire     = out_valid_reg && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
            s1_op_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_zero_reg   <= 1'b0;
            out_carry_reg  <= 1'b0;
            out_ovf_reg    <= 1'b0;
            out_op_reg     <= '0;
            op_count_reg   <= '0;
            ovf_count_reg  <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_reg <= 1'b1;
                s1_a_reg     <= bus.in_a;
                s1_b_reg     <= bus.in_b;
                s1_op_reg    <= bus.in_op;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                out_valid_reg  <= 1'b1;
                out_result_reg <= alu_result;
                out_zero_reg   <= alu_zero;
                out_carry_reg  <= alu_carry;
                out_ovf_reg    <= alu_ovf;
                out_op_reg     <= s1_op_reg;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end

            // Counters wrap freely; they are only for bring-up visibility
            if (out_fire) begin
                op_count_reg <= op_count_reg + CNT_ONE;
                if (out_ovf_reg) begin
                    ovf_count_reg <= ovf_count_reg + CNT_ONE;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_zero   = out_zero_reg;
    assign bus.out_carry  = out_carry_reg;
    assign bus.out_ovf    = out_ovf_reg;
    assign bus.out_op     = out_op_reg;
    assign bus.op_count   = op_count_reg;
    assign bus.ovf_count  = ovf_count_reg;
endmodule
